tmds_encoder: RTL and testbench



---
 rtl/tmds_pkg.sv | 18 +
 rtl/tmds_encoder.sv | 97 +++++++++
 tb/tb_tmds_encoder.sv | 158 +++++++++++++++
 3 files changed

// File: rtl/tmds_pkg.sv
// tmds_pkg: shared TMDS constants and the popcount helper.
package tmds_pkg;

    localparam int CNT_W = 5;

    localparam logic [9:0] CTRL_00 = 10'b1101010100;
    localparam logic [9:0] CTRL_01 = 10'b0010101011;
    localparam logic [9:0] CTRL_10 = 10'b0101010100;
    localparam logic [9:0] CTRL_11 = 10'b1010101011;

    function automatic logic [3:0] popcount8(input logic [7:0] v);
        logic [3:0] n;
        n = '0;
        for (int i = 0; i < 8; i++) n = n + 4'(v[i]);
        return n;
    endfunction

endpackage

// File: rtl/tmds_encoder.sv
// tmds_encoder: one-lane DVI TMDS 8b/10b encoder, three-stage pipeline.
module tmds_encoder
    import tmds_pkg::*;
(
    input  logic       clk_1x,
    input  logic       rst,
    input  logic       de,
    input  logic       c0,
    input  logic       c1,
    input  logic [7:0] data_in,
    output logic [9:0] q_out
);

    logic                    s1_de;
    logic [1:0]              s1_c;
    logic [7:0]              s1_d;
    logic [3:0]              s1_n1;
    logic [8:0]              qm;
    logic                    s2_de;
    logic [1:0]              s2_c;
    logic [8:0]              s2_qm;
    logic [3:0]              s2_n1;
    logic [3:0]              s2_n0;
    logic signed [CNT_W-1:0] cnt;
    logic signed [CNT_W-1:0] cnt_nx;
    logic signed [CNT_W-1:0] diff;
    logic [9:0]              q_nx;

    // Ignored inputs are zeroed on capture so an X there never reaches q_out.
    always_ff @(posedge clk_1x or posedge rst)
        if (rst) begin
            s1_de <= 1'b0;
            s1_c  <= 2'b00;
            s1_d  <= 8'h00;
            s1_n1 <= 4'd0;
        end else begin
            s1_de <= de;
            s1_c  <= de ? 2'b00 : {c1, c0};
            s1_d  <= de ? data_in : 8'h00;
            s1_n1 <= de ? popcount8(data_in) : 4'd0;
        end

    always_comb begin : stage_a
        logic xnor_mode;
        logic [8:0] m;
        xnor_mode = (s1_n1 > 4'd4) || (s1_n1 == 4'd4 && !s1_d[0]);
        m = '0;
        m[0] = s1_d[0];
        for (int i = 1; i < 8; i++) m[i] = xnor_mode ? ~(m[i-1] ^ s1_d[i]) : (m[i-1] ^ s1_d[i]);
        m[8] = ~xnor_mode;
        qm = m;
    end

    always_ff @(posedge clk_1x or posedge rst)
        if (rst) begin
            s2_de <= 1'b0;
            s2_c  <= 2'b00;
            s2_qm <= '0;
            s2_n1 <= 4'd0;
            s2_n0 <= 4'd0;
        end else begin
            s2_de <= s1_de;
            s2_c  <= s1_c;
            s2_qm <= qm;
            s2_n1 <= popcount8(qm[7:0]);
            s2_n0 <= 4'd8 - popcount8(qm[7:0]);
        end

    // cnt and diff are both nonzero in the middle branch, so equal sign bits mean same sign.
    always_comb begin : stage_b
        diff   = CNT_W'(s2_n1) - CNT_W'(s2_n0);
        q_nx   = s2_c == 2'b00 ? CTRL_00 : s2_c == 2'b01 ? CTRL_01 : s2_c == 2'b10 ? CTRL_10 : CTRL_11;
        cnt_nx = '0;
        if (s2_de) begin
            if (cnt == 0 || diff == 0) begin
                q_nx   = {~s2_qm[8], s2_qm[8], s2_qm[8] ? s2_qm[7:0] : ~s2_qm[7:0]};
                cnt_nx = s2_qm[8] ? cnt + diff : cnt - diff;
            end else if (cnt[CNT_W-1] == diff[CNT_W-1]) begin
                q_nx   = {1'b1, s2_qm[8], ~s2_qm[7:0]};
                cnt_nx = cnt + CNT_W'({s2_qm[8], 1'b0}) - diff;
            end else begin
                q_nx   = {1'b0, s2_qm[8], s2_qm[7:0]};
                cnt_nx = cnt + diff - (s2_qm[8] ? CNT_W'(0) : CNT_W'(2));
            end
        end
    end

    always_ff @(posedge clk_1x or posedge rst)
        if (rst) begin
            q_out <= 10'h000;
            cnt   <= '0;
        end else begin
            q_out <= q_nx;
            cnt   <= cnt_nx;
        end

endmodule

// File: tb/tb_tmds_encoder.sv
// tb_tmds_encoder: directed and random checks of tmds_encoder against a reference model.
module tb_tmds_encoder;

    typedef struct {
        logic [9:0] q;
        int         cnt;
        logic       de;
        logic [7:0] d;
        logic       has_lit;
        logic [9:0] lit;
    } exp_t;

    logic       clk_1x = 1'b0;
    logic       rst    = 1'b1;
    logic       de     = 1'b0;
    logic       c0     = 1'b0;
    logic       c1     = 1'b0;
    logic [7:0] data_in = 8'h00;
    logic [9:0] q_out;

    int   errors = 0;
    int   checks = 0;
    int   m_cnt  = 0;
    exp_t pipe[$];

    tmds_encoder dut (
        .clk_1x (clk_1x),
        .rst    (rst),
        .de     (de),
        .c0     (c0),
        .c1     (c1),
        .data_in(data_in),
        .q_out  (q_out)
    );

    always #5 clk_1x = ~clk_1x;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic logic [9:0] ref_enc(input logic e, input logic [1:0] c, input logic [7:0] d);
        logic [8:0] m;
        logic       inv;
        int         disp;
        if (!e) begin
            m_cnt = 0;
            return c == 2'd0 ? 10'h354 : c == 2'd1 ? 10'h0AB : c == 2'd2 ? 10'h154 : 10'h2AB;
        end
        m[8] = !($countones(d) > 4 || ($countones(d) == 4 && !d[0]));
        m[0] = d[0];
        for (int i = 1; i < 8; i++) m[i] = m[8] ? m[i-1] ^ d[i] : !(m[i-1] ^ d[i]);
        disp = 2 * $countones(m[7:0]) - 8;
        if (m_cnt == 0 || disp == 0) begin
            inv   = !m[8];
            m_cnt = m_cnt + (m[8] ? disp : -disp);
        end else if ((m_cnt > 0) == (disp > 0)) begin
            inv   = 1'b1;
            m_cnt = m_cnt + 2 * int'(m[8]) - disp;
        end else begin
            inv   = 1'b0;
            m_cnt = m_cnt + disp - 2 * int'(!m[8]);
        end
        return {inv, m[8], inv ? ~m[7:0] : m[7:0]};
    endfunction

    function automatic logic [7:0] decode(input logic [9:0] q);
        logic [7:0] t;
        logic [7:0] o;
        t = q[9] ? ~q[7:0] : q[7:0];
        o[0] = t[0];
        for (int i = 1; i < 8; i++) o[i] = q[8] ? t[i] ^ t[i-1] : !(t[i] ^ t[i-1]);
        return o;
    endfunction

    task automatic prime();
        exp_t e;
        pipe.delete();
        m_cnt = 0;
        e = '{q: 10'h354, cnt: 0, de: 1'b0, d: 8'h00, has_lit: 1'b0, lit: 10'h000};
        pipe.push_back(e);
        pipe.push_back(e);
    endtask

    task automatic step(input logic e, input logic [1:0] c, input logic [7:0] d, input logic hl, input logic [9:0] lit);
        exp_t x;
        int   dc;
        de = e;
        {c1, c0} = c;
        data_in = d;
        x.q = ref_enc(e, c, d);
        x.cnt = m_cnt;
        x.de = e;
        x.d = d;
        x.has_lit = hl;
        x.lit = lit;
        pipe.push_back(x);
        @(posedge clk_1x);
        #1;
        if (pipe.size() == 0) begin
            check_eq("pipe_empty", 32'd1, 32'd0);
            return;
        end
        x = pipe.pop_front();
        dc = int'(dut.cnt);
        check_eq("q_out", 32'(q_out), 32'(x.q));
        check_eq("cnt", 32'(dc), 32'(x.cnt));
        check_eq("cnt_range", 32'(dc >= -8 && dc <= 8), 32'd1);
        if (x.de) check_eq("decode", 32'(decode(q_out)), 32'(x.d));
        if (x.has_lit) check_eq("lit", 32'(q_out), 32'(x.lit));
    endtask

    initial begin
        #12;
        check_eq("rst_q", 32'(q_out), 32'h000);
        check_eq("rst_cnt", 32'(int'(dut.cnt)), 32'd0);
        @(negedge clk_1x);
        rst = 1'b0;
        prime();
        step(1'b0, 2'd0, 8'h00, 1'b1, 10'h354);
        step(1'b0, 2'd1, 8'h00, 1'b1, 10'h0AB);
        step(1'b0, 2'd2, 8'h00, 1'b1, 10'h154);
        step(1'b0, 2'd3, 8'h00, 1'b1, 10'h2AB);
        step(1'b1, 2'd3, 8'h00, 1'b1, 10'h100);
        step(1'b1, 2'd0, 8'h00, 1'b1, 10'h3FF);
        step(1'b1, 2'd1, 8'h00, 1'b1, 10'h100);
        step(1'b1, 2'd2, 8'h00, 1'b1, 10'h3FF);
        step(1'b0, 2'd0, 8'h00, 1'b1, 10'h354);
        step(1'b1, 2'd0, 8'h00, 1'b1, 10'h100);
        step(1'b0, 2'd0, 8'h00, 1'b1, 10'h354);
        step(1'b1, 2'd0, 8'hFF, 1'b1, 10'h200);
        step(1'b0, 2'd0, 8'h00, 1'b1, 10'h354);
        step(1'b1, 2'd0, 8'h55, 1'b1, 10'h133);
        step(1'b1, 2'd0, 8'h55, 1'b1, 10'h133);
        step(1'b1, 2'd0, 8'h00, 1'b0, 10'h000);
        step(1'b1, 2'd0, 8'h00, 1'b0, 10'h000);
        step(1'b1, 2'd0, 8'h00, 1'b0, 10'h000);
        rst = 1'b1;
        #1;
        check_eq("mid_rst_q", 32'(q_out), 32'h000);
        check_eq("mid_rst_cnt", 32'(int'(dut.cnt)), 32'd0);
        #1;
        rst = 1'b0;
        prime();
        step(1'b1, 2'd0, 8'h00, 1'b0, 10'h000);
        step(1'b1, 2'd0, 8'h00, 1'b0, 10'h000);
        step(1'b1, 2'd0, 8'h00, 1'b1, 10'h100);
        for (int n = 0; n < 20000; n++)
            step($urandom_range(3) != 0, 2'($urandom), 8'($urandom), 1'b0, 10'h000);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
